// File: rtl/noc_vc_tx_arbiter.sv
// Round-robin, VC-aware arbiter feeding one credit_bp_tx input port through a
// single output register that holds its flit until the target VC is free.
module noc_vc_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int D_W   = 8,
  parameter int A_W   = 8,
  parameter int VC_W  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_v,
  input  logic [N_REQ*$clog2(VC_W)-1:0]    req_vc,
  input  logic [N_REQ*(A_W+D_W+1)-1:0]     req_d,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [VC_W-1:0]                  o_v,
  output logic [A_W+D_W:0]                 o_d,
  input  logic [VC_W-1:0]                  i_b,
  output logic [$clog2(N_REQ)-1:0]         o_src,
  output logic [31:0]                      xfer_cnt
);

  localparam int VCI_W = $clog2(VC_W);
  localparam int SRC_W = $clog2(N_REQ);
  localparam int F_W   = A_W + D_W + 1;

  // Handshake: requester i hands over its flit in the cycle where
  // req_v[i] && req_ready[i]; the downstream port takes the held flit in the
  // cycle where o_v[vc] && !i_b[vc]. req_ready never depends on itself.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [VCI_W-1:0] r_vc;
  logic [F_W-1:0]   r_d;
  logic [SRC_W-1:0] r_src;
  logic [SRC_W-1:0] r_last;
  logic [31:0]      r_xfer_cnt;

  logic [VCI_W-1:0] w_req_vc [N_REQ];
  logic [SRC_W-1:0] w_cand   [N_REQ];
  logic [N_REQ-1:0] w_pref;
  logic [N_REQ-1:0] w_elig;
  logic [SRC_W-1:0] w_winner;
  logic             w_found;
  logic             w_accept;
  logic             w_load_en;
  logic             w_grant;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_req_vc[i] = req_vc[i*VCI_W +: VCI_W];
      w_pref[i]   = req_v[i] && !i_b[w_req_vc[i]];
      w_cand[i]   = SRC_W'((int'(r_last) + i + 1) % N_REQ);
    end
  end

  // Fall back to plain req_v only when every valid requester targets a
  // backpressured VC, so a blocked VC never starves a free one.
  assign w_elig = (|w_pref) ? w_pref : req_v;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_elig[w_cand[k]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[k];
      end
    end
  end

  assign w_accept  = (r_state == FULL) && !i_b[r_vc];
  assign w_load_en = (r_state == EMPTY) || w_accept;
  assign w_grant   = w_load_en && w_found && !rst;

  always_comb begin
    w_state_nxt = r_state;
    if (w_load_en) begin
      w_state_nxt = w_grant ? FULL : EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_vc       <= '0;
      r_d        <= '0;
      r_src      <= '0;
      r_last     <= SRC_W'(N_REQ - 1);
      r_xfer_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_vc   <= w_req_vc[w_winner];
        r_d    <= req_d[w_winner*F_W +: F_W];
        r_src  <= w_winner;
        r_last <= w_winner;
      end
      if (w_accept) begin
        r_xfer_cnt <= r_xfer_cnt + 32'd1;
      end
    end
  end

  assign req_ready = w_grant ? (N_REQ'(1) << w_winner) : '0;
  assign o_v       = (r_state == FULL) ? (VC_W'(1) << r_vc) : '0;
  assign o_d       = r_d;
  assign o_src     = r_src;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: doc/noc_vc_tx_arbiter.md
# noc_vc_tx_arbiter

Shares one VC-aware DVR transmit port, the input side of `credit_bp_tx`, between `N_REQ` local requesters such as client cores, verification clients or injection engines. Each cycle it picks one requester with round-robin priority. It prefers requesters whose target VC is not backpressured. The chosen flit goes into a single output register, which is held stable under backpressure until the downstream port accepts it. A transfer counter exposes accepted flits for test bookkeeping.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `D_W`, `DEFAULT_D_W`, data width
- `A_W`, `DEFAULT_A_W`, address width
- `VC_W`, `DEFAULT_VC_W`, number of VCs, one bit per VC (≥2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `req_v`  in  `N_REQ`  per-requester flit valid
- `req_vc`  in  `N_REQ` × `$clog2(VC_W)`  target VC per requester
- `req_d`  in  `N_REQ` × `A_W+D_W+1`  flit `{last, addr, data}` per requester
- `req_ready`  out  `N_REQ`  one-hot; flit `i` is consumed when `req_v[i] && req_ready[i]`
- `o_v`  out  `VC_W`  one-hot valid toward `credit_bp_tx.i_v`
- `o_d`  out  `A_W+D_W+1`  flit toward `credit_bp_tx.i_d`
- `i_b`  in  `VC_W`  per-VC backpressure from `credit_bp_tx.o_b`
- `o_src`  out  `$clog2(N_REQ)`  index of the requester whose flit is held
- `xfer_cnt`  out  32  number of accepted output flits

## Operation
- Output register `{full, vc, d, src}`. Two states:
  - EMPTY (`full`=0)
  - FULL (`full`=1)
- Outputs:
  - `o_v = full ? (1 << vc) : 0`
  - `o_d = d`
  - `o_src = src`
- `accept = full && !i_b[vc]`. This is a completed transfer; `xfer_cnt` increments by 1 and wraps at 2^32.
- `load_en = !full || accept`. The register can accept a new flit in the same cycle the old one leaves.
- Eligibility:
  - `pref[i] = req_v[i] && !i_b[req_vc[i]]`
  - If `|pref`, arbitrate over `pref`; otherwise arbitrate over `req_v`.
- Round-robin:
  - Pointer `last` holds the most recently granted index.
  - Search order is `last+1, last+2, …` modulo `N_REQ`; the first eligible index wins.
  - `last` updates only on a grant.
- Grant happens when `load_en` is high and an eligible requester exists:
  - `req_ready[winner]=1`, all other bits 0.
  - Register loads `{1, req_vc[winner], req_d[winner], winner}`.
- `load_en` high with no eligible requester: an accept moves FULL→EMPTY; otherwise stay EMPTY.
- FULL with `i_b[vc]`=1: `o_v`, `o_d` and `o_src` hold exactly. `req_ready` is all zeros.
- `req_ready` is combinational from `req_v`, `req_vc` and `i_b`; requesters must not make `req_v` depend on `req_ready`.
- The `last` bit of `req_d` is passed through opaquely. The arbiter does not lock multi-flit packets.
- Reset values:
  - `full`=0, so `o_v`=0
  - `d`=0, so `o_d`=0
  - `o_src`=0
  - `last=N_REQ-1`, so requester 0 has priority first
  - `xfer_cnt`=0
  - `req_ready`=0 while `rst` is high
- Reset mid-operation discards any held flit; no transfer is counted.
- `req_vc[i] ≥ VC_W` while `req_v[i]` is high is illegal; the bench asserts against it.

## Timing
- Grant in cycle t (`req_ready` high) → `o_v` asserted from t+1.
- Minimum latency from request to acceptance downstream is 1 cycle.
- Sustained throughput is 1 flit/cycle when `i_b`=0.
- Backpressure costs no bubble: the cycle `i_b[vc]` falls, the held flit is accepted and the next winner is loaded.
- Once `o_v[k]` rises it stays high, with `o_d` stable, until the cycle with `i_b[k]`=0.
- `xfer_cnt` reflects an accept in cycle t from cycle t+1.

## Test plan
- **Round-robin with all requesting:** `N_REQ`=4; `req_v`=4'b1111, all on VC0, `i_b`=0; hold for 8 cycles → grant order 0,1,2,3,0,1,2,3, one per cycle; `o_v`=01 every cycle from cycle 1; `xfer_cnt`=7 after cycle 8.
- **Hold under backpressure:** requester 2 sends on VC1 with `d`=0x55; `i_b[1]`=1 for 5 cycles → `o_v`=10, `o_d`=0x55, `o_src`=2 stable for 5 cycles with `req_ready`=0. Release `i_b` → accept; the next winner loads the same cycle.
- **VC-aware preference:** requester 0 targets VC0 and requester 1 targets VC1; `i_b`=01 at grant, `last`=1 → requester 1 granted despite pointer order. With `i_b`=11 → requester 0 granted (fallback).
- **Single requester, gaps:** only requester 3 pulses `req_v` every other cycle → each flit appears on `o_v` the cycle after its grant; EMPTY in between; no duplicate flits.
- **Reset mid-hold:** FULL and backpressured, assert `rst` for 1 cycle → next cycle `o_v`=0, `xfer_cnt`=0, `last`=3; the first grant after reset goes to requester 0.
- **Scoreboard soak:** 10k cycles, random `req_v` and `req_vc`, 30% random `i_b` → every consumed flit appears exactly once on `o_d`, in order per requester. The valid-held-under-bp property is never violated.
